// File: rtl/llr_reliability_sorter_if.sv
// Handshake and data bundle between the LLR reliability sorter and its neighbours.
// The producer side supplies LLR words. The consumer side takes hard decisions and the reliability order.
interface llr_reliability_sorter_if #(
  parameter int WIDTH = 8,
  parameter int LLR_W = 6,
  parameter int K_W   = 9
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH*LLR_W-1:0] llr_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [0:WIDTH-1]       c_hat;
  logic [WIDTH*K_W-1:0]   k_out;

  // Testbench / upstream view: drives words in, takes results out
  modport master (
    output in_valid, llr_in, out_ready,
    input  in_ready, out_valid, c_hat, k_out
  );

  // Sorter view
  modport slave (
    input  in_valid, llr_in, out_ready,
    output in_ready, out_valid, c_hat, k_out
  );
endinterface

// File: rtl/llr_reliability_sorter.sv
// Soft GRAND front end. It captures one word of signed LLRs and registers the hard decisions.
// It then orders the bit positions by |LLR|, least reliable first, using odd-even transposition with one pass per clock.
// The result is a 1-based index list k_out.
module llr_reliability_sorter #(
  parameter int WIDTH = 8,
  parameter int LLR_W = 6,
  parameter int K_W   = 9
) (
  input logic                   clk,
  input logic                   rst_n,
  llr_reliability_sorter_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MAG_W = LLR_W - 1;
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(WIDTH - 1);
  localparam logic [K_W-1:0]   K_ONE     = K_W'(1);
  localparam logic [LLR_W-1:0] LLR_MIN   = {1'b1, {MAG_W{1'b0}}};
  localparam logic [MAG_W-1:0] MAG_MAX   = {MAG_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r, state_nxt;
  logic [MAG_W-1:0]       mag_r   [WIDTH];
  logic [IDX_W-1:0]       idx_r   [WIDTH];
  logic [MAG_W-1:0]       mag_nxt [WIDTH];
  logic [IDX_W-1:0]       idx_nxt [WIDTH];
  logic [WIDTH-2:0]       swap_s;
  logic [WIDTH*K_W-1:0]   k_nxt;
  logic [IDX_W-1:0]       pass_cnt_r;
  logic                   capture_s;
  logic                   last_pass_s;
  logic                   release_s;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [0:WIDTH-1]       c_hat_r;
  logic [WIDTH*K_W-1:0]   k_out_r;

  // Saturating magnitude. The most negative code has no positive twin, so it clips to the largest magnitude.
  function automatic logic [MAG_W-1:0] sat_abs(input logic [LLR_W-1:0] v);
    logic [LLR_W-1:0] neg;
    neg = ~v + LLR_W'(1);
    if (!v[LLR_W-1]) begin
      return v[MAG_W-1:0];
    end else if (v == LLR_MIN) begin
      return MAG_MAX;
    end else begin
      return neg[MAG_W-1:0];
    end
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode and the one-cycle event strobes that steer the datapath
  always_comb begin
    state_nxt   = state_r;
    capture_s   = 1'b0;
    last_pass_s = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          capture_s = 1'b1;
          state_nxt = SORT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SORT: begin
        if (pass_cnt_r == LAST_PASS) begin
          last_pass_s = 1'b1;
          state_nxt   = DONE;
        end else begin
          state_nxt = SORT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          release_s = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pair-swap decisions for this pass. Pairs start at even slots on even passes and odd slots on odd passes.
  // Equal magnitudes keep ascending original index.
  always_comb begin
    swap_s = '0;
    for (int a = 0; a < WIDTH - 1; a++) begin
      swap_s[a] = (1'(a) == pass_cnt_r[0]) &&
                  ((mag_r[a] > mag_r[a+1]) ||
                   ((mag_r[a] == mag_r[a+1]) && (idx_r[a] > idx_r[a+1])));
    end
  end

  // Apply the swaps. Active pairs never overlap, so each slot moves at most once.
  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      mag_nxt[j] = mag_r[j];
      idx_nxt[j] = idx_r[j];
    end
    for (int a = 0; a < WIDTH - 1; a++) begin
      if (swap_s[a]) begin
        mag_nxt[a]   = mag_r[a+1];
        mag_nxt[a+1] = mag_r[a];
        idx_nxt[a]   = idx_r[a+1];
        idx_nxt[a+1] = idx_r[a];
      end
    end
  end

  // 1-based permutation built from the post-pass order
  always_comb begin
    k_nxt = '0;
    for (int j = 0; j < WIDTH; j++) begin
      k_nxt[j*K_W +: K_W] = K_W'(idx_nxt[j]) + K_ONE;
    end
  end

  // Datapath: capture, per-pass update, result load and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_r  <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      c_hat_r     <= '0;
      k_out_r     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        mag_r[i] <= '0;
        idx_r[i] <= '0;
      end
    end else begin
      in_ready_r <= (state_nxt == IDLE);
      if (capture_s) begin
        pass_cnt_r <= '0;
        for (int i = 0; i < WIDTH; i++) begin
          c_hat_r[i] <= bus.llr_in[i*LLR_W + LLR_W - 1];
          mag_r[i]   <= sat_abs(bus.llr_in[i*LLR_W +: LLR_W]);
          idx_r[i]   <= IDX_W'(i);
        end
      end else if (state_r == SORT) begin
        pass_cnt_r <= pass_cnt_r + IDX_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
          mag_r[i] <= mag_nxt[i];
          idx_r[i] <= idx_nxt[i];
        end
        if (last_pass_s) begin
          k_out_r     <= k_nxt;
          out_valid_r <= 1'b1;
        end
      end else if (release_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.c_hat     = c_hat_r;
  assign bus.k_out     = k_out_r;

endmodule
